uart_tx_byte_fifo: RTL
======================

UART_TX_BYTE_FIFO -- requirements
Module: uart_tx_byte_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 Parameter TIMEOUT_CLKS, default 2048, maximum clocks to wait for i_Tx_Done after a launch.
REQ-003 i_Clock  input  1  system clock; all state updates on the rising edge.
REQ-004 i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_Wr_DV  input  1  one-cycle strobe marking a received byte from the UART receiver.
REQ-006 i_Wr_Byte  input  8  received byte, valid when i_Wr_DV=1.
REQ-007 i_Tx_Active  input  1  UART transmitter busy flag.
REQ-008 i_Tx_Done  input  1  one-cycle pulse from the transmitter at the end of the stop bit.
REQ-009 i_Clr_Ovf  input  1  clears the sticky overflow and error flags.
REQ-010 o_Tx_DV  output  1  one-cycle launch strobe to the transmitter.
REQ-011 o_Tx_Byte  output  8  byte to transmit; valid with o_Tx_DV, held until the next launch.
REQ-012 o_Count  output  log2(DEPTH)+1  stored entries, 0..DEPTH.
REQ-013 o_Empty / o_Full  output  1 each  o_Count==0 / o_Count==DEPTH.
REQ-014 o_Overflow  output  1  sticky; a write was dropped.
REQ-015 o_Tx_Err  output  1  sticky; launch timed out.

Function
REQ-016 Write: i_Wr_DV=1 and o_Full=0 stores i_Wr_Byte at wr_ptr; wr_ptr increments modulo DEPTH, wrapping DEPTH-1 -> 0.
REQ-017 Write with o_Full=1 is dropped and sets o_Overflow, even if a pop occurs in the same cycle; memory and pointers are unchanged.
REQ-018 Write and pop in the same cycle (FIFO not full): both take effect; o_Count is unchanged.
REQ-019 No bypass path: a byte written into an empty FIFO becomes visible to the read FSM one cycle after the write edge.
REQ-020 FSM states: IDLE, LAUNCH, WAIT_DONE.
REQ-021 IDLE -> LAUNCH when o_Empty=0 and i_Tx_Active=0; otherwise remain in IDLE.
REQ-022 LAUNCH lasts exactly one cycle.
  - o_Tx_DV=1.
  - o_Tx_Byte=mem[rd_ptr].
  - Pop: rd_ptr increments modulo DEPTH; o_Count decrements.
  - Next state is WAIT_DONE.
REQ-023 WAIT_DONE -> IDLE on i_Tx_Done=1; the timeout counter is cleared on entry to WAIT_DONE.
REQ-024 WAIT_DONE timeout: if the counter reaches TIMEOUT_CLKS without i_Tx_Done, set o_Tx_Err and go to IDLE; the popped byte is not retried.
REQ-025 i_Tx_Done outside WAIT_DONE is ignored.
REQ-026 Latency: a write sampled at edge N into an empty FIFO with the transmitter idle gives o_Tx_DV=1 in the cycle after edge N+1.
REQ-027 Back-to-back: after i_Tx_Done, the next launch needs at least one cycle in IDLE; the next o_Tx_DV is no earlier than 2 cycles after i_Tx_Done.
REQ-028 o_Tx_DV is never high on two consecutive cycles.
REQ-029 i_Clr_Ovf=1 clears o_Overflow and o_Tx_Err; a simultaneous setting event wins, and the flag stays 1.
REQ-030 o_Empty, o_Full and o_Count are registered and consistent with each other every cycle.

Reset
REQ-031 While i_Rst_n=0, the following are forced immediately, independent of i_Clock:
  - pointers=0, o_Count=0, o_Empty=1, o_Full=0;
  - o_Overflow=0, o_Tx_Err=0;
  - o_Tx_DV=0, o_Tx_Byte=8'h00;
  - state=IDLE, timeout counter=0.
REQ-032 Reset mid-operation discards all stored bytes and abandons any launch in progress; memory contents need not be cleared.
REQ-033 Deassertion of i_Rst_n is synchronous to i_Clock (done by an external synchronizer); the first write is accepted on the first edge after release.

Verification
REQ-034 Single byte: write 8'h41 with i_Tx_Active=0 -> o_Tx_DV pulses 2 edges later with o_Tx_Byte=8'h41; o_Count goes 0->1->0.
REQ-035 Ordering: write 8'h41, 8'h42, 8'h43, 8'h44 back-to-back while the transmitter model is busy -> four launches, in order, each after i_Tx_Done; o_Empty=1 at the end.
REQ-036 Full/overflow: DEPTH=16 with i_Tx_Active held 1, write 17 bytes 8'h00..8'h10 -> o_Full=1 and o_Count=16 after the 16th write; 8'h10 is dropped and o_Overflow=1; drained bytes are 8'h00..8'h0F; i_Clr_Ovf clears the flag.
REQ-037 Wrap and simultaneous access: keep 3 entries occupied while writing and popping on the same cycles for 40 bytes -> pointers wrap, o_Count stays 3 on simultaneous cycles, and no byte is lost or reordered.
REQ-038 Timeout: launch 8'h55 and never pulse i_Tx_Done -> after TIMEOUT_CLKS=2048 cycles o_Tx_Err=1, the FSM returns to IDLE, and the next queued byte launches.
REQ-039 Reset mid-operation: assert i_Rst_n=0 during WAIT_DONE with 5 bytes queued -> all outputs take their reset values immediately; after release, no o_Tx_DV until a new write occurs.

Source files
------------

// File: rtl/uart_tx_byte_fifo.sv
// uart_tx_byte_fifo: byte FIFO between a UART receiver and a UART transmitter.
// Received bytes are queued, then launched one at a time into the transmitter
// with a one-cycle strobe. After each launch the FSM waits for the end of the
// transmitted frame, giving up after TIMEOUT_CLKS cycles.
module uart_tx_byte_fifo #(
    parameter int DEPTH        = 16,
    parameter int TIMEOUT_CLKS = 2048
) (
    input  logic                     i_Clock,
    input  logic                     i_Rst_n,
    input  logic                     i_Wr_DV,
    input  logic [7:0]               i_Wr_Byte,
    input  logic                     i_Tx_Active,
    input  logic                     i_Tx_Done,
    input  logic                     i_Clr_Ovf,
    output logic                     o_Tx_DV,
    output logic [7:0]               o_Tx_Byte,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Empty,
    output logic                     o_Full,
    output logic                     o_Overflow,
    output logic                     o_Tx_Err
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LAUNCH    = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_next;
    logic [1:0]    state;
    logic [TW-1:0] tmo_cnt;
    logic          push;
    logic          pop;
    logic          drop;
    logic          tmo_hit;

    // A full FIFO refuses the write even when a pop happens on the same edge.
    assign push    = i_Wr_DV && !o_Full;
    assign drop    = i_Wr_DV && o_Full;
    assign pop     = (state == LAUNCH);
    assign tmo_hit = (state == WAIT_DONE) && !i_Tx_Done && (tmo_cnt == TMO_LAST);

    // Occupancy after this edge; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next = o_Count;
        if (push && !pop) begin
            count_next = o_Count + 1'b1;
        end else if (!push && pop) begin
            count_next = o_Count - 1'b1;
        end
    end

    // Storage array: data only, so it carries no reset.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr] <= i_Wr_Byte;
        end
    end

    // Pointers and registered occupancy flags, all derived from count_next.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_Count <= '0;
            o_Empty <= 1'b1;
            o_Full  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            o_Count <= count_next;
            o_Empty <= (count_next == '0);
            o_Full  <= (count_next == DEPTH_C);
        end
    end

    // Launch FSM: IDLE picks up the head byte, LAUNCH pops it, WAIT_DONE
    // holds until the frame ends or the timeout expires.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= 8'h00;
        end else begin
            o_Tx_DV <= 1'b0;
            case (state)
                IDLE: begin
                    if (!o_Empty && !i_Tx_Active) begin
                        state     <= LAUNCH;
                        o_Tx_DV   <= 1'b1;
                        o_Tx_Byte <= mem[rd_ptr];
                    end
                end
                LAUNCH: begin
                    state   <= WAIT_DONE;
                    tmo_cnt <= '0;
                end
                WAIT_DONE: begin
                    if (i_Tx_Done || tmo_hit) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a setting event on the same edge beats the clear.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Overflow <= 1'b0;
            o_Tx_Err   <= 1'b0;
        end else begin
            if (drop) begin
                o_Overflow <= 1'b1;
            end else if (i_Clr_Ovf) begin
                o_Overflow <= 1'b0;
            end
            if (tmo_hit) begin
                o_Tx_Err <= 1'b1;
            end else if (i_Clr_Ovf) begin
                o_Tx_Err <= 1'b0;
            end
        end
    end

endmodule
